// File: rtl/gain_stage_pkg.sv
// gain_stage_pkg: shared defaults, unity-gain helper and the shift/clamp function
//   used by the gain stage pipeline.
package gain_stage_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_GAIN_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 10;
    // Wide enough for any DATA_WIDTH+GAIN_WIDTH product the stage is built with.
    localparam int MAX_W          = 128;

    typedef struct packed {
        logic             clip;
        logic [MAX_W-1:0] val;
    } sat_t;

    function automatic int unity_gain(input int frac);
        return 1 << frac;
    endfunction

    // Arithmetic shift (floor) followed by an optional clamp to a dw-bit signed range.
    // With sat low the caller keeps the low dw bits, which wraps.
    function automatic sat_t sat_shift(input logic signed [MAX_W-1:0] product,
                                       input int dw, input int frac, input logic sat);
        logic signed [MAX_W-1:0] sh, hi, lo;
        sat_t r;
        sh = product >>> frac;
        hi = (MAX_W'(1) <<< (dw - 1)) - MAX_W'(1);
        lo = ~hi;
        r.clip = sat && (sh > hi || sh < lo);
        r.val = !r.clip ? sh : (sh > hi ? hi : lo);
        return r;
    endfunction

endpackage

// File: rtl/fifo.sv
// fifo: first-word-fall-through FIFO; head word on dout while empty is low.
//   clock, reset (async, active-high); wr_en/din/full write side;
//   rd_en/dout/empty read side. Writes when full and reads when empty are ignored.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      cnt;
    logic             push, pop;

    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;
    assign dout  = empty ? '0 : mem[rp];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + AW'(1);
            if (pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clock)
        if (push) mem[wp] <= din;

endmodule

// File: rtl/gain_stage_mc_mac_pipe.sv
// gain_mac_pipe: two-stage multiply / shift-saturate pipeline with valid and tag.
//   issue/din/gain/ch enter S1; S2 presents valid, dout, dout_ch and clip_hit
//   (clip_hit marks a sample that was clamped).
module gain_mac_pipe
    import gain_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int GAIN_WIDTH = DEF_GAIN_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int CH_W       = 1,
    parameter int SATURATE   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [GAIN_WIDTH-1:0] gain,
    input  logic [CH_W-1:0]       ch,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CH_W-1:0]       dout_ch,
    output logic                  clip_hit
);
    localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH;

    logic signed [PROD_W-1:0] s1_prod;
    logic                     s1_valid;
    logic [CH_W-1:0]          s1_ch;
    sat_t                     r;
    logic                     unused_hi;

    always_comb r = sat_shift(MAX_W'(s1_prod), DATA_WIDTH, FRAC_BITS, SATURATE != 0);
    assign unused_hi = ^r.val[MAX_W-1:DATA_WIDTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_ch    <= '0;
            valid    <= 1'b0;
            dout     <= '0;
            dout_ch  <= '0;
            clip_hit <= 1'b0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_prod <= PROD_W'($signed(din)) * PROD_W'($signed(gain));
                s1_ch   <= ch;
            end
            valid <= s1_valid;
            if (s1_valid) begin
                dout     <= r.val[DATA_WIDTH-1:0];
                dout_ch  <= s1_ch;
                clip_hit <= r.clip;
            end
        end
    end

endmodule

// File: rtl/gain_stage_mc.sv
// gain_stage_mc: multi-channel flow-controlled gain stage with per-channel gains.
//   clock, reset (async, active-high)
//   din/in_wr_en/in_full          : input FIFO write side
//   gain_wr_en/gain_ch/gain_din   : per-channel gain load
//   dout/dout_ch/out_rd_en/out_empty : output FIFO read side (FWFT)
//   clip/clip_clr                 : sticky per-channel saturation flags
module gain_stage_mc
    import gain_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int GAIN_WIDTH = DEF_GAIN_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int SATURATE   = 1,
    localparam int CH_W      = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  in_wr_en,
    output logic                  in_full,
    input  logic                  gain_wr_en,
    input  logic [CH_W-1:0]       gain_ch,
    input  logic [GAIN_WIDTH-1:0] gain_din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CH_W-1:0]       dout_ch,
    input  logic                  out_rd_en,
    output logic                  out_empty,
    output logic [NUM_CH-1:0]     clip,
    input  logic                  clip_clr
);
    localparam int OW = $clog2(FIFO_DEPTH) + 1;

    logic [GAIN_WIDTH-1:0] gain [NUM_CH];
    logic [CH_W-1:0]       ch_cnt;
    logic [OW-1:0]         occ;
    logic [DATA_WIDTH-1:0] in_head;
    logic                  in_empty, issue, pop;
    logic                  s2_valid, s2_clip, out_full;
    logic [DATA_WIDTH-1:0] s2_data;
    logic [CH_W-1:0]       s2_ch;
    logic [NUM_CH-1:0]     clip_set;

    // occ covers S1, S2 and the output FIFO, so an issued sample always has a slot.
    assign issue    = !in_empty && occ < OW'(FIFO_DEPTH);
    assign pop      = out_rd_en && !out_empty;
    assign clip_set = (s2_valid && s2_clip) ? NUM_CH'(1) << s2_ch : '0;

    fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clock(clock), .reset(reset),
        .wr_en(in_wr_en), .din(din), .full(in_full),
        .rd_en(issue), .dout(in_head), .empty(in_empty)
    );

    gain_mac_pipe #(
        .DATA_WIDTH(DATA_WIDTH), .GAIN_WIDTH(GAIN_WIDTH), .FRAC_BITS(FRAC_BITS),
        .CH_W(CH_W), .SATURATE(SATURATE)
    ) u_pipe (
        .clock(clock), .reset(reset),
        .issue(issue), .din(in_head), .gain(gain[ch_cnt]), .ch(ch_cnt),
        .valid(s2_valid), .dout(s2_data), .dout_ch(s2_ch), .clip_hit(s2_clip)
    );

    fifo #(.WIDTH(DATA_WIDTH + CH_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clock(clock), .reset(reset),
        .wr_en(s2_valid), .din({s2_ch, s2_data}), .full(out_full),
        .rd_en(out_rd_en), .dout({dout_ch, dout}), .empty(out_empty)
    );

    logic unused_full;
    assign unused_full = out_full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) gain[i] <= GAIN_WIDTH'(unity_gain(FRAC_BITS));
            ch_cnt <= '0;
            occ    <= '0;
            clip   <= '0;
        end else begin
            // Gain registers update at the edge, so a same-cycle issue sees the old value.
            for (int i = 0; i < NUM_CH; i++)
                if (gain_wr_en && int'(gain_ch) == i) gain[i] <= gain_din;
            if (issue) ch_cnt <= int'(ch_cnt) == NUM_CH - 1 ? '0 : ch_cnt + CH_W'(1);
            if (issue && !pop) occ <= occ + OW'(1);
            else if (pop && !issue) occ <= occ - OW'(1);
            clip <= (clip & ~{NUM_CH{clip_clr}}) | clip_set;
        end
    end

endmodule

// File: tb/tb_gain_stage_mc.sv
// tb_gain_stage_mc: directed + randomized bench against a queue-level reference model.
module tb_gain_stage_mc;
    localparam int     DEPTH = 16;
    localparam int     NCH   = 2;
    localparam longint SMAX  = 64'sd2147483647;
    localparam longint SMIN  = -SMAX - 1;

    logic        clock = 0, reset = 1;
    logic [31:0] din = 0;
    logic        in_wr_en = 0, gain_wr_en = 0, out_rd_en = 0, clip_clr = 0;
    logic [0:0]  gain_ch = 0;
    logic [15:0] gain_din = 0;
    logic        in_full, in_full_w, out_empty, out_empty_w;
    logic [31:0] dout, dout_w;
    logic [0:0]  dout_ch, dout_ch_w;
    logic [1:0]  clip, clip_w;

    int tests = 0, fails = 0;
    bit run = 0;

    always #5 clock = ~clock;

    gain_stage_mc dut (
        .clock(clock), .reset(reset), .din(din), .in_wr_en(in_wr_en), .in_full(in_full),
        .gain_wr_en(gain_wr_en), .gain_ch(gain_ch), .gain_din(gain_din),
        .dout(dout), .dout_ch(dout_ch), .out_rd_en(out_rd_en), .out_empty(out_empty),
        .clip(clip), .clip_clr(clip_clr)
    );

    gain_stage_mc #(.SATURATE(0)) dut_w (
        .clock(clock), .reset(reset), .din(din), .in_wr_en(in_wr_en), .in_full(in_full_w),
        .gain_wr_en(gain_wr_en), .gain_ch(gain_ch), .gain_din(gain_din),
        .dout(dout_w), .dout_ch(dout_ch_w), .out_rd_en(out_rd_en), .out_empty(out_empty_w),
        .clip(clip_w), .clip_clr(clip_clr)
    );

    task automatic check(input string n, input longint a, input longint e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", n, a, e);
        end
    endtask

    // Reference model: samples flow as queue entries; an issued sample lands in the
    // output queue two edges after issue.
    typedef struct {
        logic [31:0] vs, vw;
        int          ch;
        bit          clp;
        longint      due;
    } ent_t;

    int      inq[$];
    ent_t    pend[$], outq[$];
    shortint mgain[NCH];
    int      mch;
    logic [1:0] mclip;
    longint  cyc;

    always @(posedge clock or posedge reset) begin
        bit rd, iss, wr;
        ent_t e;
        logic [1:0] set;
        longint p, s;
        if (reset) begin
            inq.delete(); pend.delete(); outq.delete();
            foreach (mgain[i]) mgain[i] = 16'sd1024;
            mch = 0; mclip = 0; cyc = 0;
        end else begin
            cyc++;
            rd  = out_rd_en && outq.size() > 0;
            iss = inq.size() > 0 && (pend.size() + outq.size()) < DEPTH;
            wr  = in_wr_en && inq.size() < DEPTH;
            set = 0;
            if (rd) void'(outq.pop_front());
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e = pend.pop_front();
                outq.push_back(e);
                if (e.clp) set[e.ch] = 1'b1;
            end
            if (iss) begin
                p = longint'(inq.pop_front()) * longint'(mgain[mch]);
                s = p >>> 10;
                e.vw  = s[31:0];
                e.clp = s > SMAX || s < SMIN;
                e.vs  = s > SMAX ? 32'h7fffffff : s < SMIN ? 32'h80000000 : s[31:0];
                e.ch  = mch;
                e.due = cyc + 2;
                pend.push_back(e);
                mch = (mch + 1) % NCH;
            end
            if (wr) inq.push_back(din);
            mclip = (clip_clr ? 2'b00 : mclip) | set;
            if (gain_wr_en) mgain[gain_ch] = gain_din;
        end
    end

    always @(negedge clock) begin
        if (!reset && run) begin
            check("in_full", in_full, inq.size() == DEPTH);
            check("in_full_w", in_full_w, inq.size() == DEPTH);
            check("out_empty", out_empty, outq.size() == 0);
            check("out_empty_w", out_empty_w, outq.size() == 0);
            check("clip", clip, mclip);
            check("clip_w", clip_w, 0);
            if (outq.size() > 0) begin
                check("dout", dout, outq[0].vs);
                check("dout_w", dout_w, outq[0].vw);
                check("dout_ch", dout_ch, outq[0].ch);
                check("dout_ch_w", dout_ch_w, outq[0].ch);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write(input logic [31:0] d);
        in_wr_en = 1; din = d; tick(); in_wr_en = 0;
    endtask

    task automatic set_gain(input logic [0:0] c, input logic [15:0] g);
        gain_wr_en = 1; gain_ch = c; gain_din = g; tick(); gain_wr_en = 0;
    endtask

    task automatic pop_chk(input string n, input logic [31:0] e, input logic [31:0] ew, input int ech);
        int k = 0;
        while (out_empty && k < 50) begin tick(); k++; end
        check({n, "_avail"}, out_empty, 0);
        check(n, dout, e);
        check({n, "_w"}, dout_w, ew);
        check({n, "_ch"}, dout_ch, ech);
        out_rd_en = 1; tick(); out_rd_en = 0;
    endtask

    initial begin
        int vals[4] = '{1, -1, 100, -100};
        int n;
        repeat (3) tick();
        check("rst_in_full", in_full, 0);
        check("rst_out_empty", out_empty, 1);
        check("rst_clip", clip, 0);
        check("rst_dout", dout, 0);
        check("rst_dout_ch", dout_ch, 0);
        reset = 0; run = 1;

        for (int i = 0; i < 4; i++) begin
            in_wr_en = 1; din = vals[i]; tick();
            check("latency", out_empty, (i < 3) ? 1 : 0);
        end
        in_wr_en = 0;
        for (int i = 0; i < 4; i++) pop_chk("unity", vals[i], vals[i], i % 2);

        set_gain(0, 16'd512);
        set_gain(1, 16'd2048);
        write(-3); write(32'h4000_0000); write(7);
        pop_chk("half_neg", -2, -2, 0);
        pop_chk("sat_hi", 32'h7fff_ffff, 32'h8000_0000, 1);
        pop_chk("half_pos", 3, 3, 0);
        check("clip_set", clip, 2'b10);
        check("clip_set_w", clip_w, 0);
        clip_clr = 1; tick(); clip_clr = 0;
        check("clip_clr", clip, 0);

        write(1); write(100);
        gain_wr_en = 1; gain_ch = 0; gain_din = 16'd2048; tick(); gain_wr_en = 0;
        write(1); write(100);
        pop_chk("a_ch1", 2, 2, 1);
        pop_chk("old_gain", 50, 50, 0);
        pop_chk("c_ch1", 2, 2, 1);
        pop_chk("new_gain", 200, 200, 0);

        for (int i = 0; i < 40; i++) begin
            in_wr_en = 1; din = $urandom(); tick();
        end
        in_wr_en = 0;
        check("fill_full", in_full, 1);
        out_rd_en = 1; n = 0;
        for (int k = 0; k < 100; k++) begin
            if (!out_empty) n++;
            tick();
        end
        out_rd_en = 0;
        check("drain_cnt", n, 32);
        check("drained", out_empty, 1);

        for (int c = 0; c < 3000; c++) begin
            in_wr_en   = $urandom_range(0, 9) < 6;
            din        = $urandom_range(0, 7) == 0 ? ($urandom_range(0, 1) ? 32'h7fff_ffff : 32'h8000_0000) : $urandom();
            out_rd_en  = $urandom_range(0, 9) < (c < 1500 ? 3 : 7);
            gain_wr_en = $urandom_range(0, 15) == 0;
            gain_ch    = 1'($urandom_range(0, 1));
            gain_din   = 16'($urandom());
            clip_clr   = $urandom_range(0, 31) == 0;
            tick();
        end
        in_wr_en = 0; gain_wr_en = 0; clip_clr = 0; out_rd_en = 1;
        repeat (60) tick();
        out_rd_en = 0;

        set_gain(0, 16'd2048);
        set_gain(1, 16'd2048);
        repeat (5) write(32'h4000_0000);
        check("pre_rst_clip", clip, 2'b11);
        reset = 1; tick();
        check("mid_rst_out_empty", out_empty, 1);
        check("mid_rst_in_full", in_full, 0);
        check("mid_rst_clip", clip, 0);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_dout_ch", dout_ch, 0);
        tick(); reset = 0;
        write(1000); write(1000);
        pop_chk("post_rst_ch0", 1000, 1000, 0);
        pop_chk("post_rst_ch1", 1000, 1000, 1);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
